// File: rtl/cpu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl_pkg
// Shared definitions for the RV32I multi-cycle sequencer:
//   - seq_state_e     : 3-bit sequencer state encoding
//   - PC_SEL_*        : next-PC source select driven to the PC mux
//   - ALU_* (control) : decoder ALU codes that steer the next-PC select
//   - next_pc_sel()   : maps a retiring instruction's ALU code and the
//                       branch flag onto a PC_SEL_* value
// Only the ALU codes that change control flow live here; every other code
// falls through to PC+4.
// ---------------------------------------------------------------------------
package cpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_MEM    = 3'd3,
    SEQ_WB     = 3'd4,
    SEQ_HALT   = 3'd5,
    SEQ_FAULT  = 3'd6
  } seq_state_e;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM   = 2'b01;
  localparam logic [1:0] PC_SEL_RS1   = 2'b10;

  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;

  // Conditional branches only redirect when the ALU says the condition holds.
  function automatic logic [1:0] next_pc_sel(input logic [5:0] code,
                                             input logic       taken);
    case (code)
      ALU_JAL:  return PC_SEL_IMM;
      ALU_JALR: return PC_SEL_RS1;
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU:
        return taken ? PC_SEL_IMM : PC_SEL_PLUS4;
      default:  return PC_SEL_PLUS4;
    endcase
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl_wait_timer
// Counts cycles spent waiting for a memory acknowledge and flags when the
// wait has reached MEM_TIMEOUT. MEM_TIMEOUT = 0 disables the flag entirely.
// Parameters:
//   MEM_TIMEOUT : wait cycles allowed before expired (0 = never)
//   TMO_W       : counter width, 2**TMO_W must exceed MEM_TIMEOUT
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear (has priority over count_en)
//   count_en    : increment this cycle
//   expired     : count has reached MEM_TIMEOUT (combinational)
// ---------------------------------------------------------------------------
module cpu_seq_ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (count == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl
// Multi-cycle sequencer for the RV32I core. Steps every instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB and drives all datapath enables.
// HALT and FAULT are terminal until reset.
// Parameters:
//   MEM_TIMEOUT : max imem/dmem wait cycles before FAULT (0 = never)
//   TMO_W       : wait counter width
//   CNT_W       : perf counter width
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   imem_req/imem_ack, ir_we   : instruction fetch handshake, IR load
//   alucode, reg_we, is_load,
//   is_store, is_halt          : decoder outputs (from the held IR)
//   br_taken                   : ALU branch condition
//   dmem_req/dmem_we/dmem_ack  : data memory handshake
//   rf_we, wb_sel              : regfile write enable, 1 = load data
//   pc_we, pc_sel              : PC update enable and source select
//   halted, fault              : sticky terminal status
//   cycle_cnt, instret_cnt     : perf counters
// Build option:
//   SEQ_PERF_COUNTERS_EN : when defined, cycle_cnt/instret_cnt are live
//                          counters; otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic [5:0]       alucode,
  input  logic             reg_we,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  seq_state_e state;
  logic       in_wait;
  logic       wait_ack;
  logic       tmo_expired;

  // The timer only runs while a memory request is outstanding; holding it
  // clear in every other state means it starts from zero on entry.
  assign in_wait  = (state == SEQ_FETCH) || (state == SEQ_MEM);
  assign wait_ack = (state == SEQ_FETCH) ? imem_ack : dmem_ack;

  cpu_seq_ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!in_wait),
    .count_en (in_wait && !wait_ack),
    .expired  (tmo_expired)
  );

  // An acknowledge arriving on the cycle the timer expires still wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_FETCH;
    end else begin
      case (state)
        SEQ_FETCH: begin
          if (imem_ack)         state <= SEQ_DECODE;
          else if (tmo_expired) state <= SEQ_FAULT;
        end
        SEQ_DECODE: state <= SEQ_EXEC;
        SEQ_EXEC: begin
          if (is_halt)                  state <= SEQ_HALT;
          else if (is_load || is_store) state <= SEQ_MEM;
          else                          state <= SEQ_WB;
        end
        SEQ_MEM: begin
          if (dmem_ack)         state <= SEQ_WB;
          else if (tmo_expired) state <= SEQ_FAULT;
        end
        SEQ_WB:    state <= SEQ_FETCH;
        SEQ_HALT:  state <= SEQ_HALT;
        SEQ_FAULT: state <= SEQ_FAULT;
        default:   state <= SEQ_FETCH;
      endcase
    end
  end

  // Enables are decoded straight from state so an async reset drops any
  // in-flight request in the same cycle.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PLUS4;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      SEQ_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      SEQ_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
      end
      SEQ_WB: begin
        pc_we  = 1'b1;
        rf_we  = reg_we;
        wb_sel = is_load;
        pc_sel = next_pc_sel(alucode, br_taken);
      end
      SEQ_HALT:  halted = 1'b1;
      SEQ_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // Both counters freeze once the core stops; they wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != SEQ_HALT && state != SEQ_FAULT) cycle_q <= cycle_q + CNT_W'(1);
      if (state == SEQ_WB) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_seq_ctrl
// Drives whole instructions through the sequencer with random memory
// latencies and random stray acknowledges, and predicts every cycle's
// enables and counters from the instruction kind and its latencies.
// ---------------------------------------------------------------------------
module tb_cpu_seq_ctrl;
  import cpu_seq_ctrl_pkg::*;

  localparam int TMO   = 8;
  localparam int TMO_W = 4;
  localparam int CNT_W = 32;

  // Non-control decoder codes; any value outside JAL/JALR/branches works.
  localparam logic [5:0] TB_ALU_LUI = 6'd0;
  localparam logic [5:0] TB_ALU_LW  = 6'd11;
  localparam logic [5:0] TB_ALU_SW  = 6'd16;
  localparam logic [5:0] TB_ALU_ADD = 6'd27;

`ifdef SEQ_PERF_COUNTERS_EN
  localparam logic [CNT_W-1:0] PERF_MASK = '1;
`else
  localparam logic [CNT_W-1:0] PERF_MASK = '0;
`endif

  typedef enum int {K_ADD, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_JALR, K_LUI, K_HALT} kind_e;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req, imem_ack, ir_we;
  logic [5:0]       alucode;
  logic             reg_we, is_load, is_store, is_halt, br_taken;
  logic             dmem_req, dmem_we, dmem_ack;
  logic             rf_we, wb_sel, pc_we;
  logic [1:0]       pc_sel;
  logic             halted, fault;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [10:0]      ctl_vec;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] m_cycles;
  logic [CNT_W-1:0] m_instret;

  cpu_seq_ctrl #(
    .MEM_TIMEOUT (TMO),
    .TMO_W       (TMO_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .ir_we       (ir_we),
    .alucode     (alucode),
    .reg_we      (reg_we),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_halt     (is_halt),
    .br_taken    (br_taken),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .halted      (halted),
    .fault       (fault),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  assign ctl_vec = {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, halted, fault};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic ireq, input logic irwe, input logic dreq,
                                     input logic dwe, input logic rfwe, input logic wbs,
                                     input logic pcwe, input logic [1:0] ps,
                                     input logic h, input logic f);
    return {ireq, irwe, dreq, dwe, rfwe, wbs, pcwe, ps, h, f};
  endfunction

  // Inputs are already driven (posedge+1); check mid-cycle, then advance.
  task automatic stepCycle(input string tag, input logic [10:0] exp, input bit live, input bit retire);
    #1;
    checkOutput({tag, " ctl"}, 64'(ctl_vec), 64'(exp));
    checkOutput({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(m_cycles & PERF_MASK));
    checkOutput({tag, " instret_cnt"}, 64'(instret_cnt), 64'(m_instret & PERF_MASK));
    @(posedge clk);
    #1;
    if (live)   m_cycles++;
    if (retire) m_instret++;
  endtask

  task automatic strayAcks();
    imem_ack = 1'($urandom_range(0, 1));
    dmem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic doReset();
    rst      = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    m_cycles  = '0;
    m_instret = '0;
    stepCycle("reset", mk(1, 0, 0, 0, 0, 0, 0, PC_SEL_PLUS4, 0, 0), 0, 0);
    rst = 1'b0;
  endtask

  task automatic terminalTail(input string tag, input bit is_fault, input int n);
    for (int i = 0; i < n; i++) begin
      strayAcks();
      stepCycle(tag, mk(0, 0, 0, 0, 0, 0, 0, PC_SEL_PLUS4, !is_fault, is_fault), 0, 0);
    end
  endtask

  task automatic applyStimulus(input kind_e k, input bit br, input bit rd0,
                               input int fetch_delay, input int mem_delay, input bit abort_mem);
    logic       ld, st, hl, rw, ack;
    logic [1:0] ps;
    logic [5:0] code;
    int         n;
    ld = 0; st = 0; hl = 0; rw = !rd0; ps = PC_SEL_PLUS4; code = TB_ALU_ADD;
    case (k)
      K_ADD:  code = TB_ALU_ADD;
      K_LW:   begin code = TB_ALU_LW; ld = 1; end
      K_SW:   begin code = TB_ALU_SW; st = 1; rw = 0; end
      K_BEQ:  begin code = ALU_BEQ; rw = 0; ps = br ? PC_SEL_IMM : PC_SEL_PLUS4; end
      K_BNE:  begin code = ALU_BNE; rw = 0; ps = br ? PC_SEL_IMM : PC_SEL_PLUS4; end
      K_JAL:  begin code = ALU_JAL; ps = PC_SEL_IMM; end
      K_JALR: begin code = ALU_JALR; ps = PC_SEL_RS1; end
      K_LUI:  code = TB_ALU_LUI;
      default: begin code = TB_ALU_ADD; hl = 1; rw = 0; end
    endcase
    alucode = code; reg_we = rw; is_load = ld; is_store = st; is_halt = hl; br_taken = br;

    n = (fetch_delay > TMO) ? TMO : fetch_delay;
    for (int i = 0; i <= n; i++) begin
      ack      = (i == fetch_delay);
      imem_ack = ack;
      dmem_ack = 1'($urandom_range(0, 1));
      stepCycle("fetch", mk(1, ack, 0, 0, 0, 0, 0, PC_SEL_PLUS4, 0, 0), 1, 0);
    end
    if (fetch_delay > TMO) begin
      terminalTail("fetch fault", 1, 6);
      return;
    end

    strayAcks();
    stepCycle("decode", '0, 1, 0);
    strayAcks();
    stepCycle("exec", '0, 1, 0);

    if (hl) begin
      terminalTail("halt", 0, 20);
      return;
    end

    if (ld || st) begin
      n = (mem_delay > TMO) ? TMO : mem_delay;
      for (int i = 0; i <= n; i++) begin
        dmem_ack = (i == mem_delay);
        imem_ack = 1'($urandom_range(0, 1));
        if (abort_mem) begin
          #2;
          checkOutput("pre-abort dmem_req", 64'(dmem_req), 64'(1));
          rst = 1'b1;
          #1;
          checkOutput("abort dmem_req", 64'(dmem_req), 64'(0));
          checkOutput("abort imem_req", 64'(imem_req), 64'(1));
          checkOutput("abort cycle_cnt", 64'(cycle_cnt), 64'(0));
          @(posedge clk);
          #1;
          rst       = 1'b0;
          m_cycles  = '0;
          m_instret = '0;
          return;
        end
        stepCycle("mem", mk(0, 0, 1, st, 0, 0, 0, PC_SEL_PLUS4, 0, 0), 1, 0);
      end
      if (mem_delay > TMO) begin
        terminalTail("mem fault", 1, 6);
        return;
      end
    end

    strayAcks();
    stepCycle("wb", mk(0, 0, 0, 0, rw, ld, 1, ps, 0, 0), 1, 1);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 0; dmem_ack = 0; alucode = '0;
    reg_we = 0; is_load = 0; is_store = 0; is_halt = 0; br_taken = 0;
    m_cycles = '0; m_instret = '0;
    #1;
    doReset();

    // Directed cases
    applyStimulus(K_ADD,  0, 0, 0, 0, 0);
    applyStimulus(K_LW,   0, 0, 0, 3, 0);
    applyStimulus(K_SW,   0, 0, 1, 0, 0);
    applyStimulus(K_BEQ,  1, 0, 0, 0, 0);
    applyStimulus(K_BEQ,  0, 0, 0, 0, 0);
    applyStimulus(K_JALR, 1, 0, 2, 0, 0);
    applyStimulus(K_JAL,  0, 1, 0, 0, 0);
    applyStimulus(K_LW,   0, 0, 0, TMO, 0);
    applyStimulus(K_ADD,  0, 0, TMO, 0, 0);

    // Random instruction mix
    for (int i = 0; i < 40; i++) begin
      applyStimulus(kind_e'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, TMO)), 0);
    end

    // Data-side timeout, then instruction-side timeout
    applyStimulus(K_LW, 0, 0, 0, 100, 0);
    doReset();
    applyStimulus(K_ADD, 0, 0, 50, 0, 0);
    doReset();

    // Reset in the middle of a memory access
    applyStimulus(K_SW, 0, 0, 0, 2, 0);
    applyStimulus(K_LW, 0, 0, 0, 2, 1);
    applyStimulus(K_ADD, 0, 0, 0, 0, 0);

    // Halt, then recovery
    applyStimulus(K_HALT, 0, 0, 1, 0, 0);
    doReset();
    applyStimulus(K_SW, 1, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
